// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, oversampling ratio and the feeder FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_OSR    = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STROBE    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART feeder: circular buffer with registered count/full/empty and a sticky overflow flag.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   baud_clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   overflow
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [UART_DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    count_nxt;
    logic                   push;
    logic                   pop;

    // full is the registered flag, so a push is dropped even when a pop frees a slot in the same cycle
    assign push = wr_en && !full && !clear;
    assign pop  = rd_en && !empty;

    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge baud_clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == '0);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch sequencer feeding the UART transmitter's write/datain inputs.
// Optional inter-frame gap enabled by defining UART_TX_FEEDER_GAP_EN.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                   baud_clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   tx_write,
    output logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_idle,
    input  logic                   tx_done,
    output feeder_state_t          dbg_state
);

    feeder_state_t          state;
    logic                   strb_cnt;
    logic                   pop;
    logic [UART_DATA_W-1:0] fifo_rd_data;

    // Launch handshake: a frame starts only when the FIFO has a byte and tx_idle=1; tx_write is then
    // held for two cycles with tx_data stable, and the next launch waits for the tx_done pulse.
    assign pop       = (state == S_IDLE) && !empty && tx_idle;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    uart_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

`ifdef UART_TX_FEEDER_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    logic [GAP_W-1:0] gap_cnt;
`else
    // GAP_CYCLES has no effect without the gap feature
    logic unused_gap;
    assign unused_gap = (GAP_CYCLES != 0);
`endif

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_write <= 1'b0;
            tx_data  <= '0;
            strb_cnt <= 1'b0;
`ifdef UART_TX_FEEDER_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data  <= fifo_rd_data;
                        tx_write <= 1'b1;
                        strb_cnt <= 1'b0;
                        state    <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (strb_cnt) begin
                        tx_write <= 1'b0;
                        state    <= S_WAIT_BUSY;
                    end else begin
                        strb_cnt <= 1'b1;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!tx_idle)
                        state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tx_done) begin
`ifdef UART_TX_FEEDER_GAP_EN
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= GAP_W'(GAP_CYCLES);
                            state   <= S_GAP;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end
`ifdef UART_TX_FEEDER_GAP_EN
                S_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    tx_write <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural transmitter that checks each launched byte.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int FRAME = 20;
`ifdef UART_TX_FEEDER_GAP_EN
    localparam int EXP_RELAUNCH = 17;
`else
    localparam int EXP_RELAUNCH = 1;
`endif

    logic          baud_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          clear    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [7:0]    wr_data  = 8'h00;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic          overflow;
    logic          busy;
    logic          tx_write;
    logic [7:0]    tx_data;
    logic          tx_idle;
    logic          tx_done;
    feeder_state_t dbg_state;

    logic          m_idle;
    logic          write_q;
    logic          hold_busy = 1'b0;
    int            bcnt;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_fail   = 0;
    logic [7:0]    exp_q[$];

    uart_tx_feeder #(
        .DEPTH_LOG2(4),
        .GAP_CYCLES(16)
    ) dut (
        .baud_clk  (baud_clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .busy      (busy),
        .tx_write  (tx_write),
        .tx_data   (tx_data),
        .tx_idle   (tx_idle),
        .tx_done   (tx_done),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 baud_clk = ~baud_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- transmitter model ----------------
    assign tx_idle = m_idle && !hold_busy;

    always @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle  <= 1'b1;
            tx_done <= 1'b0;
            write_q <= 1'b0;
            bcnt    <= 0;
        end else begin
            write_q <= tx_write;
            tx_done <= 1'b0;
            if (tx_write && !write_q && tx_idle) begin
                m_idle <= 1'b0;
                bcnt   <= FRAME;
                if (exp_q.size() == 0)
                    check("unexpected_launch", {24'h0, tx_data}, 32'hFFFF_FFFF);
                else
                    check("frame_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end else if (!m_idle) begin
                if (bcnt == 1) begin
                    m_idle  <= 1'b1;
                    tx_done <= 1'b1;
                end
                bcnt <= bcnt - 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (tx_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, {31'h0, tx_done}, 32'h1);
    endtask

    task automatic wait_state(input string tag, input feeder_state_t s);
        int n;
        n = 0;
        while (dbg_state !== s && n < 100) begin
            tick();
            n++;
        end
        check(tag, {29'h0, dbg_state}, {29'h0, s});
    endtask

    // cycles from the edge that samples tx_done to the edge that raises tx_write
    task automatic measure_relaunch(output int n);
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_write && n < 60);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int launches;

        repeat (3) tick();
        check("rst_tx_write", {31'h0, tx_write}, 32'h0);
        check("rst_tx_data",  {24'h0, tx_data}, 32'h0);
        check("rst_empty",    {31'h0, empty}, 32'h1);
        check("rst_full",     {31'h0, full}, 32'h0);
        check("rst_count",    {27'h0, count}, 32'h0);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        check("rst_busy",     {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        tick();

        // single byte launch timing
        exp_q.push_back(8'hA5);
        push(8'hA5);
        check("a5_count_e0", {27'h0, count}, 32'h1);
        check("a5_write_e0", {31'h0, tx_write}, 32'h0);
        tick();
        check("a5_write_e1", {31'h0, tx_write}, 32'h1);
        check("a5_data_e1",  {24'h0, tx_data}, 32'hA5);
        check("a5_empty_e1", {31'h0, empty}, 32'h1);
        check("a5_busy_e1",  {31'h0, busy}, 32'h1);
        tick();
        check("a5_write_e2", {31'h0, tx_write}, 32'h1);
        tick();
        check("a5_write_e3", {31'h0, tx_write}, 32'h0);
        check("a5_state_e3", {29'h0, dbg_state}, {29'h0, S_WAIT_BUSY});
        wait_done("a5_done");
        tick();
        tick();
        check("a5_idle_after", {31'h0, busy}, 32'h0);
        check("a5_sb_drained", exp_q.size(), 32'h0);

        // three back-to-back frames
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("b2b_count", {27'h0, count}, 32'h2);
        wait_done("b2b_done1");
        measure_relaunch(n);
        check("b2b_relaunch1", n, EXP_RELAUNCH);
        check("b2b_data2", {24'h0, tx_data}, 32'h02);
        wait_done("b2b_done2");
        measure_relaunch(n);
        check("b2b_relaunch2", n, EXP_RELAUNCH);
        check("b2b_data3", {24'h0, tx_data}, 32'h03);
        check("b2b_empty", {31'h0, empty}, 32'h1);
        wait_done("b2b_done3");
        tick();
        tick();
        check("b2b_count_end", {27'h0, count}, 32'h0);
        check("b2b_sb_drained", exp_q.size(), 32'h0);

        // fill and overflow with the transmitter held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'h10 + 8'(i));
            if (i == 14)
                check("ovf_full_15", {31'h0, full}, 32'h0);
        end
        check("ovf_full_16",  {31'h0, full}, 32'h1);
        check("ovf_count_16", {27'h0, count}, 32'h10);
        check("ovf_flag_16",  {31'h0, overflow}, 32'h0);
        push(8'hEE);
        check("ovf_flag_17",  {31'h0, overflow}, 32'h1);
        check("ovf_count_17", {27'h0, count}, 32'h10);
        repeat (3) tick();
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count",    {27'h0, count}, 32'h0);
        check("clr_empty",    {31'h0, empty}, 32'h1);
        check("clr_full",     {31'h0, full}, 32'h0);
        check("clr_overflow", {31'h0, overflow}, 32'h0);
        clear   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        check("clrwr_count",    {27'h0, count}, 32'h0);
        check("clrwr_overflow", {31'h0, overflow}, 32'h0);
        hold_busy = 1'b0;
        repeat (5) tick();
        check("clr_no_launch", {31'h0, busy}, 32'h0);

        // clear during a frame
        exp_q.push_back(8'hB1);
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        check("mid_count", {27'h0, count}, 32'h2);
        wait_state("mid_wait_done", S_WAIT_DONE);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mid_clr_count", {27'h0, count}, 32'h0);
        check("mid_busy", {31'h0, busy}, 32'h1);
        wait_done("mid_done");
        launches = 0;
        repeat (30) begin
            tick();
            if (tx_write)
                launches++;
        end
        check("mid_no_relaunch", launches, 32'h0);
        check("mid_sb_drained", exp_q.size(), 32'h0);

        // asynchronous reset in S_WAIT_DONE
        exp_q.push_back(8'hC4);
        push(8'hC4);
        push(8'hC5);
        wait_state("rst_mid_state", S_WAIT_DONE);
        check("rst_mid_pre_data", {24'h0, tx_data}, 32'hC4);
        rst_n = 1'b0;
        #2;
        check("arst_tx_data",  {24'h0, tx_data}, 32'h0);
        check("arst_tx_write", {31'h0, tx_write}, 32'h0);
        check("arst_count",    {27'h0, count}, 32'h0);
        check("arst_empty",    {31'h0, empty}, 32'h1);
        check("arst_busy",     {31'h0, busy}, 32'h0);
        check("arst_state",    {29'h0, dbg_state}, {29'h0, S_IDLE});
        #2;
        rst_n = 1'b1;
        launches = 0;
        repeat (30) begin
            tick();
            if (tx_write)
                launches++;
        end
        check("arst_no_launch", launches, 32'h0);
        check("arst_empty_after", {31'h0, empty}, 32'h1);
        check("arst_sb_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
